// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller and its datapath:
// FSM state encodings, opcode/funct constants, select encodings and
// the bit positions of the one-hot instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Funct field for R-type, instruction bits [5:0]
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  // Register-file write address select
  localparam logic [1:0] A3_RD    = 2'b00;
  localparam logic [1:0] A3_RT    = 2'b01;
  localparam logic [1:0] A3_RA    = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WD_C     = 2'b00;
  localparam logic [1:0] WD_D     = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;
  localparam logic [1:0] WD_IMM   = 2'b11;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_RA   = 2'b11;

  // One-hot instruction class bit positions
  localparam int CLS_ADDU  = 0;
  localparam int CLS_SUBU  = 1;
  localparam int CLS_JR    = 2;
  localparam int CLS_ORI   = 3;
  localparam int CLS_LUI   = 4;
  localparam int CLS_LW    = 5;
  localparam int CLS_SW    = 6;
  localparam int CLS_BEQ   = 7;
  localparam int CLS_JAL   = 8;
  localparam int CLS_OTHER = 9;
  localparam int CLS_W     = 10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class.
// Anything not recognised, including the all-zero nop, is "other".
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [CLS_W-1:0] cls
);

  // Exactly one class bit is set for every opcode/funct pair
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[CLS_ADDU]  = 1'b1;
          FN_SUBU: cls[CLS_SUBU]  = 1'b1;
          FN_JR:   cls[CLS_JR]    = 1'b1;
          default: cls[CLS_OTHER] = 1'b1;
        endcase
      end
      OP_ORI:  cls[CLS_ORI]   = 1'b1;
      OP_LUI:  cls[CLS_LUI]   = 1'b1;
      OP_LW:   cls[CLS_LW]    = 1'b1;
      OP_SW:   cls[CLS_SW]    = 1'b1;
      OP_BEQ:  cls[CLS_BEQ]   = 1'b1;
      OP_JAL:  cls[CLS_JAL]   = 1'b1;
      default: cls[CLS_OTHER] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller: FETCH/DECODE/EXE/MEM/WB Moore FSM driving the
// datapath write enables and selects. The opcode/funct inputs come from
// the instruction register and are stable from DECODE until retire.
// Every instruction ends with exactly one PCWr cycle, which is also Done.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Equ,
  output logic       PCWr,
  output logic       IRWr,
  output logic       GRFWr,
  output logic       DMWr,
  output logic       EXTOp,
  output logic       BSel,
  output logic [1:0] ALUOp,
  output logic [1:0] A3Sel,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       Br,
  output logic [2:0] State,
  output logic       Done
);

  logic [CLS_W-1:0] cls;
  state_e           state_q, state_d;
  logic             pc_wr, ir_wr, grf_wr, dm_wr;
  logic [1:0]       sel_alu_op;
  logic             sel_b, sel_ext;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // ALU/B/extend selects implied by the class; held through EXE, MEM and WB
  always_comb begin
    sel_alu_op = ALU_ADD;
    sel_b      = 1'b0;
    sel_ext    = 1'b0;
    if (cls[CLS_SUBU]) sel_alu_op = ALU_SUB;
    if (cls[CLS_ORI]) begin
      sel_alu_op = ALU_OR;
      sel_b      = 1'b1;
    end
    if (cls[CLS_LW] || cls[CLS_SW]) begin
      sel_b   = 1'b1;
      sel_ext = 1'b1;
    end
    if (cls[CLS_BEQ]) begin
      sel_alu_op = ALU_SUB;
      sel_ext    = 1'b1;
    end
  end

  // Next state and per-state outputs; unlisted outputs stay 0
  always_comb begin
    state_d = S_FETCH;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    grf_wr  = 1'b0;
    dm_wr   = 1'b0;
    EXTOp   = 1'b0;
    BSel    = 1'b0;
    ALUOp   = ALU_ADD;
    A3Sel   = A3_RD;
    WDSel   = WD_C;
    NPCOp   = NPC_PC4;
    Br      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls[CLS_JAL]) begin
          pc_wr  = 1'b1;
          NPCOp  = NPC_JAL;
          grf_wr = 1'b1;
          A3Sel  = A3_RA;
          WDSel  = WD_PC4;
        end else if (cls[CLS_JR]) begin
          pc_wr  = 1'b1;
          NPCOp  = NPC_RA;
        end else if (cls[CLS_OTHER]) begin
          pc_wr  = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALUOp = sel_alu_op;
        BSel  = sel_b;
        EXTOp = sel_ext;
        if (cls[CLS_BEQ]) begin
          pc_wr = 1'b1;
          NPCOp = NPC_BR;
          Br    = Equ;
        end else if (cls[CLS_LW] || cls[CLS_SW]) begin
          state_d = S_MEM;
        end else if (cls[CLS_ADDU] || cls[CLS_SUBU] || cls[CLS_ORI] || cls[CLS_LUI]) begin
          state_d = S_WB;
        end else begin
          // Instruction register changed under us: retire rather than stall
          pc_wr = 1'b1;
        end
      end
      S_MEM: begin
        ALUOp = sel_alu_op;
        BSel  = sel_b;
        EXTOp = sel_ext;
        if (cls[CLS_SW]) begin
          dm_wr = 1'b1;
          pc_wr = 1'b1;
        end else if (cls[CLS_LW]) begin
          state_d = S_WB;
        end else begin
          pc_wr = 1'b1;
        end
      end
      S_WB: begin
        ALUOp  = sel_alu_op;
        BSel   = sel_b;
        EXTOp  = sel_ext;
        grf_wr = 1'b1;
        pc_wr  = 1'b1;
        if (cls[CLS_ORI] || cls[CLS_LUI] || cls[CLS_LW]) A3Sel = A3_RT;
        if (cls[CLS_LUI]) WDSel = WD_IMM;
        if (cls[CLS_LW])  WDSel = WD_D;
      end
      default: ;
    endcase
  end

  // State register; reset returns to FETCH from any state
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign PCWr  = pc_wr  & ~reset;
  assign IRWr  = ir_wr  & ~reset;
  assign GRFWr = grf_wr & ~reset;
  assign DMWr  = dm_wr  & ~reset;
  assign Done  = PCWr;
  assign State = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: reset checks, a table of one instruction per
// class with known latency and retire outputs, randomized instruction
// streams against a per-output reference model, and mid-instruction resets.
module tb_mc_controller;

  localparam int W = 19;

  typedef struct packed {
    logic       pcwr, irwr, grfwr, dmwr, extop, bsel;
    logic [1:0] aluop, a3sel, wdsel, npcop;
    logic       br;
    logic [2:0] state;
    logic       done;
  } out_t;

  typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_OTHER} icls_e;

  typedef struct {
    logic [5:0] op, fn;
    logic       equ;
    int         lat;
    logic       grf, dm;
    logic [1:0] a3, wd, npc;
    logic       br;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       Equ;
  logic       PCWr, IRWr, GRFWr, DMWr, EXTOp, BSel, Br, Done;
  logic [1:0] ALUOp, A3Sel, WDSel, NPCOp;
  logic [2:0] State;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Equ(Equ),
    .PCWr(PCWr), .IRWr(IRWr), .GRFWr(GRFWr), .DMWr(DMWr), .EXTOp(EXTOp),
    .BSel(BSel), .ALUOp(ALUOp), .A3Sel(A3Sel), .WDSel(WDSel), .NPCOp(NPCOp),
    .Br(Br), .State(State), .Done(Done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = '{PCWr, IRWr, GRFWr, DMWr, EXTOp, BSel, ALUOp, A3Sel, WDSel, NPCOp, Br, State, Done};
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic icls_e classify(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00 && fn == 6'h21) return C_ADDU;
    if (op == 6'h00 && fn == 6'h23) return C_SUBU;
    if (op == 6'h00 && fn == 6'h08) return C_JR;
    if (op == 6'h0d) return C_ORI;
    if (op == 6'h0f) return C_LUI;
    if (op == 6'h23) return C_LW;
    if (op == 6'h2b) return C_SW;
    if (op == 6'h04) return C_BEQ;
    if (op == 6'h03) return C_JAL;
    return C_OTHER;
  endfunction

  function automatic int path_len(icls_e c);
    case (c)
      C_JAL, C_JR, C_OTHER: return 2;
      C_BEQ:                return 3;
      C_LW:                 return 5;
      default:              return 4;
    endcase
  endfunction

  // State visited at cycle k of an instruction
  function automatic int state_at(icls_e c, int k);
    if (k <= 2) return k;
    if (k == 3) return (c == C_LW || c == C_SW) ? 3 : 4;
    return 4;
  endfunction

  // Expected outputs, derived output by output from the instruction rules
  function automatic out_t model(icls_e c, int k, logic equ);
    out_t o;
    int   st;
    st      = state_at(c, k);
    o       = '0;
    o.state = 3'(st);
    o.irwr  = (st == 0);
    o.pcwr  = (k == path_len(c) - 1);
    o.done  = o.pcwr;
    if (o.pcwr)
      o.npcop = (c == C_JAL) ? 2'b10 : (c == C_JR) ? 2'b11 : (c == C_BEQ) ? 2'b01 : 2'b00;
    o.grfwr = (c == C_JAL && st == 1) || st == 4;
    if (o.grfwr) begin
      case (c)
        C_JAL: begin o.a3sel = 2'b10; o.wdsel = 2'b10; end
        C_ORI: begin o.a3sel = 2'b01; o.wdsel = 2'b00; end
        C_LUI: begin o.a3sel = 2'b01; o.wdsel = 2'b11; end
        C_LW:  begin o.a3sel = 2'b01; o.wdsel = 2'b01; end
        default: ;
      endcase
    end
    o.dmwr = (c == C_SW && st == 3);
    if (st >= 2) begin
      case (c)
        C_SUBU:     o.aluop = 2'b01;
        C_ORI:      begin o.aluop = 2'b10; o.bsel = 1'b1; end
        C_LW, C_SW: begin o.bsel = 1'b1; o.extop = 1'b1; end
        C_BEQ:      begin o.aluop = 2'b01; o.extop = 1'b1; end
        default: ;
      endcase
    end
    o.br = (c == C_BEQ && st == 2 && equ);
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  // Enter with the DUT in FETCH, 1 time unit after an edge, reset low.
  task automatic resync();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rand_equ,
                           input logic equ_fix, input string tag,
                           output int lat, output out_t retire);
    icls_e c;
    int    n;
    logic  eq[8];
    out_t  got, exp;
    c = classify(op, fn);
    n = path_len(c);
    for (int k = 0; k < 8; k++) eq[k] = rand_equ ? 1'($urandom_range(0, 1)) : equ_fix;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model(c, k, eq[k]));
    opcode = op;
    funct  = fn;
    lat    = 0;
    retire = '0;
    for (int k = 0; k < 8; k++) begin
      Equ = eq[k];
      #1;
      got = dut_out();
      if (exp_q.size() == 0) begin
        check($sformatf("%s_overrun_c%0d", tag, k), 32'(got), 32'(1'b0));
        break;
      end
      exp = exp_q.pop_front();
      check($sformatf("%s_op%0h_c%0d", tag, op, k), 32'(got), 32'(exp));
      if (got.done) begin
        lat    = k + 1;
        retire = got;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      check($sformatf("%s_timeout", tag), 32'(lat), 32'(n));
      resync();
    end else begin
      check($sformatf("%s_len", tag), 32'(lat), 32'(n));
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input logic [5:0] op, input logic [5:0] fn, input int edges,
                           input logic [2:0] st, input string tag);
    opcode = op;
    funct  = fn;
    Equ    = 1'b0;
    for (int k = 0; k < edges; k++) begin
      @(posedge clk); #1;
    end
    check({tag, "_state"}, 32'(State), 32'(st));
    reset = 1'b1;
    #1;
    check({tag, "_we_off"}, 32'({PCWr, IRWr, GRFWr, DMWr, Done}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check({tag, "_refetch"}, 32'({State, IRWr}), 32'({3'd0, 1'b1}));
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[12];

  initial begin
    int   lat;
    out_t ret;
    logic [5:0] op, fn;
    int   r;

    tbl[0]  = '{6'h00, 6'h21, 1'b0, 4, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0}; // addu
    tbl[1]  = '{6'h00, 6'h23, 1'b0, 4, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0}; // subu
    tbl[2]  = '{6'h0d, 6'h15, 1'b0, 4, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0}; // ori
    tbl[3]  = '{6'h0f, 6'h00, 1'b1, 4, 1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0}; // lui
    tbl[4]  = '{6'h23, 6'h04, 1'b0, 5, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0}; // lw
    tbl[5]  = '{6'h2b, 6'h08, 1'b1, 4, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0}; // sw
    tbl[6]  = '{6'h04, 6'h00, 1'b1, 3, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1}; // beq taken
    tbl[7]  = '{6'h04, 6'h3f, 1'b0, 3, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0}; // beq not taken
    tbl[8]  = '{6'h03, 6'h00, 1'b0, 2, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 1'b0}; // jal
    tbl[9]  = '{6'h00, 6'h08, 1'b1, 2, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0}; // jr
    tbl[10] = '{6'h00, 6'h00, 1'b0, 2, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0}; // nop
    tbl[11] = '{6'h3f, 6'h3f, 1'b1, 2, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0}; // 111111

    reset  = 1'b1;
    opcode = '0;
    funct  = '0;
    Equ    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_we", 32'({PCWr, IRWr, GRFWr, DMWr, Done}), 32'(0));
    check("rst_state", 32'(State), 32'(0));
    reset = 1'b0;
    #1;
    check("post_rst_fetch", 32'({State, IRWr}), 32'({3'd0, 1'b1}));

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, 1'b0, tbl[i].equ, $sformatf("tbl%0d", i), lat, ret);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_retire", i),
            32'({ret.grfwr, ret.dmwr, ret.a3sel, ret.wdsel, ret.npcop, ret.br}),
            32'({tbl[i].grf, tbl[i].dm, tbl[i].a3, tbl[i].wd, tbl[i].npc, tbl[i].br}));
    end

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 11));
      op = 6'($urandom_range(0, 63));
      fn = 6'($urandom_range(0, 63));
      case (r)
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h23; end
        2: begin op = 6'h00; fn = 6'h08; end
        3: op = 6'h0d;
        4: op = 6'h0f;
        5: op = 6'h23;
        6: op = 6'h2b;
        7: op = 6'h04;
        8: op = 6'h03;
        9: begin op = 6'h00; fn = 6'h00; end
        11: op = 6'h00;
        default: ;
      endcase
      run_instr(op, fn, 1'b1, 1'b0, "rnd", lat, ret);
    end

    reset_mid(6'h23, 6'h00, 3, 3'd3, "rst_lw_mem");
    reset_mid(6'h2b, 6'h00, 3, 3'd3, "rst_sw_mem");
    reset_mid(6'h00, 6'h21, 3, 3'd4, "rst_addu_wb");
    reset_mid(6'h04, 6'h00, 2, 3'd2, "rst_beq_exe");

    run_instr(6'h23, 6'h00, 1'b1, 1'b0, "after_rst", lat, ret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high, sampled on the rising clk edge.
REQ-002 SHALL have inputs: opcode input 6, instruction bits [31:26] from the instruction register; funct input 6, bits [5:0]; Equ input 1, ALU equality flag.
REQ-003 SHALL have write-enable outputs, each 1 bit: PCWr, PC update enable; IRWr, instruction-register load; GRFWr, register-file write; DMWr, data-memory write.
REQ-004 SHALL have select outputs: EXTOp 1, 1=sign-extend / 0=zero-extend; BSel 1, 1=Ext / 0=RD2; ALUOp 2, 00 add / 01 sub / 10 or; A3Sel 2, 00 rd / 01 rt / 10 $31; WDSel 2, 00 C / 01 D / 10 PC4 / 11 imm32; NPCOp 2, 00 PC+4 / 01 branch / 10 jal target / 11 RA.
REQ-005 SHALL have status outputs: Br 1, branch taken; State 3, current FSM state; Done 1, instruction-retire pulse.

Function
REQ-006 SHALL be a Moore FSM with states FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; encodings 5-7 SHALL return to FETCH on the next edge with all write enables 0.
REQ-007 SHALL classify instructions: addu (000000/100001), subu (000000/100011), jr (000000/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011; every other encoding, including all-zero nop, SHALL be class "other".
REQ-008 FETCH: IRWr=1; next DECODE.
REQ-009 DECODE: jal asserts PCWr=1, NPCOp=10, GRFWr=1, A3Sel=10, WDSel=10, then FETCH; jr asserts PCWr=1, NPCOp=11, then FETCH; "other" asserts PCWr=1, NPCOp=00, then FETCH; all remaining classes go to EXE.
REQ-010 EXE: addu uses ALUOp 00, subu ALUOp 01, both BSel=0; ori uses ALUOp 10, BSel=1, EXTOp=0; lw/sw use ALUOp 00, BSel=1, EXTOp=1; these classes go to WB, except lw/sw, which go to MEM.
REQ-011 EXE for beq: ALUOp=01, BSel=0, EXTOp=1, PCWr=1, NPCOp=01, Br=Equ, combinational from Equ; next FETCH.
REQ-012 EXE for lui: no datapath action; next WB.
REQ-013 MEM: lw holds the EXE ALU/B selects and goes to WB; sw holds the EXE selects and asserts DMWr=1, PCWr=1, NPCOp=00, then FETCH.
REQ-014 WB: GRFWr=1, PCWr=1, NPCOp=00; addu/subu use A3Sel=00, WDSel=00; ori uses A3Sel=01, WDSel=00; lui uses A3Sel=01, WDSel=11; lw uses A3Sel=01, WDSel=01; ALU selects are held from EXE; next FETCH.
REQ-015 SHALL drive Done=PCWr; each instruction SHALL produce exactly one PCWr pulse.
REQ-016 All unlisted outputs in a state SHALL be 0; Br SHALL be 0 outside beq EXE.
REQ-017 SHALL give these latencies in cycles: jal/jr/other 2; beq 3; sw 4; addu/subu/ori/lui 4; lw 5.
REQ-018 GRFWr and DMWr SHALL never be asserted in the same cycle; IRWr SHALL be asserted only in FETCH.

Reset
REQ-019 When reset=1 at an edge, the next State SHALL be FETCH regardless of the current state, including mid-instruction.
REQ-020 While reset=1, PCWr, IRWr, GRFWr and DMWr SHALL all be forced to 0 combinationally.
REQ-021 After reset deasserts, the first cycle SHALL be FETCH with IRWr=1.

Structure
REQ-022 A shared definitions file SHALL hold the state encodings, opcode/funct constants and the ALUOp/A3Sel/WDSel/NPCOp encodings, for reuse by the datapath.
REQ-023 SHALL contain one combinational sub-module, mc_decode, mapping opcode/funct to a one-hot instruction class; the FSM and the output logic SHALL remain in mc_controller.

Verification
REQ-024 addu (000000/100001): State 0,1,2,4,0; GRFWr=1 with A3Sel=00, WDSel=00 only in state 4, with PCWr=1 in the same cycle.
REQ-025 lw (100011): State 0,1,2,3,4,0; ALUOp=00, BSel=1, EXTOp=1 in states 2-4; GRFWr=1, WDSel=01 in state 4; DMWr never 1.
REQ-026 sw (101011): State 0,1,2,3,0; DMWr=1 and PCWr=1 only in state 3; GRFWr never 1.
REQ-027 beq (000100) with Equ=1: state-2 outputs are PCWr=1, NPCOp=01, Br=1; with Equ=0, Br=0 and PCWr=1.
REQ-028 jal (000011): State 0,1,0; in state 1, GRFWr=1, A3Sel=10, WDSel=10, NPCOp=10; opcode 111111 gives State 0,1,0 with PCWr=1, NPCOp=00, GRFWr=0.
REQ-029 reset=1 during an lw in state 3: no write enable in that cycle, next State=0, and the following cycle has IRWr=1.
